pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC and target address width.
REQ-002 SHALL have parameter RESET_ADDR, default 32'h0000_0000: PC value loaded on reset (ADDR_W bits).
REQ-003 SHALL have parameter HOLD_W, default 3: width of the hold flag bus.
REQ-004 SHALL have parameter HOLD_PC_LEVEL, default 1: PC is held when hold_flag_i >= this value.
REQ-005 SHALL have parameter CNT_W, default 32: width of the accepted-fetch counter.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous reset, active-low.
REQ-008 SHALL have port jump_flag_i, input, 1: jump request this cycle.
REQ-009 SHALL have port jump_addr_i, input, ADDR_W: jump target.
REQ-010 SHALL have port hold_flag_i, input, HOLD_W: pipeline hold level.
REQ-011 SHALL have port trap_flag_i, input, 1: trap request (present only with PC_TRAP_EN).
REQ-012 SHALL have port trap_addr_i, input, ADDR_W: trap vector (present only with PC_TRAP_EN).
REQ-013 SHALL have port fetch_ready_i, input, 1: fetch stage accepts pc_o this cycle.
REQ-014 SHALL have port pc_o, output, ADDR_W: current PC, registered.
REQ-015 SHALL have port pc_valid_o, output, 1: pc_o is offered to fetch.
REQ-016 SHALL have port redirect_o, output, 1: registered one-cycle pulse after PC loaded from jump/trap.
REQ-017 SHALL have port misalign_o, output, 1: registered one-cycle pulse after a redirect target had addr[1:0] != 0.
REQ-018 SHALL have port fetch_cnt_o, output, CNT_W: count of accepted fetches.

Function
REQ-019 SHALL implement states BOOT, RUN, HOLD; all outputs registered.
REQ-020 SHALL leave BOOT for RUN after exactly one cycle, pc_o unchanged, unless a redirect occurs, which loads pc_o and also enters RUN.
REQ-021 SHALL drive pc_valid_o = 1 only in RUN; 0 in BOOT and HOLD.
REQ-022 SHALL define accept = pc_valid_o && fetch_ready_i && (hold_flag_i < HOLD_PC_LEVEL).
REQ-023 SHALL apply per-cycle priority: reset > trap > jump > hold > accept > keep.
REQ-024 SHALL on trap (or, if none, jump) load pc_o with target with bits [1:0] forced to 0, enter RUN, and assert redirect_o next cycle; applies in any state, including HOLD and BOOT.
REQ-025 SHALL assert misalign_o next cycle when the selected redirect target has bits [1:0] != 0.
REQ-026 SHALL, with no redirect and hold_flag_i >= HOLD_PC_LEVEL, keep pc_o and enter or stay in HOLD.
REQ-027 SHALL in HOLD with hold released and no redirect, return to RUN with pc_o unchanged; no fetch is accepted in that cycle.
REQ-028 SHALL on accept with no redirect increment pc_o by 4, modulo 2^ADDR_W (all-ones-minus-3 wraps to 0, no flag).
REQ-029 SHALL keep pc_o unchanged in RUN when fetch_ready_i = 0 and no redirect is present.
REQ-030 SHALL increment fetch_cnt_o by 1 on every accept, including an accept coincident with a redirect, and wrap modulo 2^CNT_W.
REQ-031 SHALL give a redirect coincident with accept priority for pc_o; the offered PC counts as fetched.

Reset
REQ-032 SHALL when rst = 0 at a rising edge set pc_o = RESET_ADDR, state = BOOT, pc_valid_o = 0, redirect_o = 0, misalign_o = 0, fetch_cnt_o = 0, overriding every other input, including mid-HOLD or coincident redirect.
REQ-033 SHALL take no asynchronous action on rst.

Configuration
REQ-034 SHALL when macro PC_TRAP_EN is defined include trap_flag_i/trap_addr_i with priority over jump per REQ-023.
REQ-035 SHALL when PC_TRAP_EN is undefined omit both ports and all trap logic; redirects come from jump only.

Verification
REQ-036 SHALL check reset: rst=0 two cycles then 1 -> pc_o=RESET_ADDR, pc_valid_o=0 one cycle, then 1; fetch_cnt_o=0.
REQ-037 SHALL check streaming: fetch_ready_i=1 for 4 cycles from 0x0 -> pc_o 0x4,0x8,0xC,0x10; fetch_cnt_o=4; ready=0 one cycle -> pc_o holds.
REQ-038 SHALL check hold: hold_flag_i=1 at pc 0x8 for 3 cycles -> pc_o=0x8, pc_valid_o=0; release -> valid=1 next cycle, then 0xC after accept.
REQ-039 SHALL check jump during hold: hold_flag_i=2, jump 0x100 -> pc_o=0x100, redirect_o=1 one cycle, state RUN.
REQ-040 SHALL check misaligned/trap: jump 0x203 -> pc_o=0x200, misalign_o=1; with PC_TRAP_EN, trap 0x80 + jump 0x40 same cycle -> pc_o=0x80.
REQ-041 SHALL check wrap: pc_o=0xFFFF_FFFC, accept -> pc_o=0x0000_0000.

Source files
------------

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with BOOT/RUN/HOLD sequencing, jump redirect and fetch counting.
// Define PC_TRAP_EN to add the trap_flag_i/trap_addr_i vector input, which outranks jump.
module pc_gen #(
   parameter int unsigned       ADDR_W        = 32,
   parameter logic [ADDR_W-1:0] RESET_ADDR    = ADDR_W'(32'h0000_0000),
   parameter int unsigned       HOLD_W        = 3,
   parameter int unsigned       HOLD_PC_LEVEL = 1,
   parameter int unsigned       CNT_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jump_flag_i,
   input  logic [ADDR_W-1:0] jump_addr_i,
   input  logic [HOLD_W-1:0] hold_flag_i,
`ifdef PC_TRAP_EN
   input  logic              trap_flag_i,
   input  logic [ADDR_W-1:0] trap_addr_i,
`endif
   input  logic              fetch_ready_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic              pc_valid_o,
   output logic              redirect_o,
   output logic              misalign_o,
   output logic [CNT_W-1:0]  fetch_cnt_o
);

   localparam int unsigned       PC_STEP  = 4;
   localparam logic [HOLD_W-1:0] HOLD_LVL = HOLD_W'(HOLD_PC_LEVEL);

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   pc_q, pc_d;
   logic                valid_q, valid_d;
   logic                redirect_q, redirect_d;
   logic                misalign_q, misalign_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                redir_req;
   logic [ADDR_W-1:0]   redir_tgt;
   logic                hold_req;
   logic                accept;

   // Redirect source select: trap (when built in) wins over jump.
   always_comb begin
      redir_req = jump_flag_i;
      redir_tgt = jump_addr_i;
`ifdef PC_TRAP_EN
      if (trap_flag_i) begin
         redir_req = 1'b1;
         redir_tgt = trap_addr_i;
      end
`endif
   end

   assign hold_req = (hold_flag_i >= HOLD_LVL);
   assign accept   = valid_q && fetch_ready_i && !hold_req;

   // Next-state and next-output logic.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      redirect_d = 1'b0;
      misalign_d = 1'b0;
      cnt_d      = cnt_q;

      // An offered PC counts as fetched even when a redirect replaces it.
      if (accept) begin
         cnt_d = cnt_q + CNT_W'(1);
      end

      if (redir_req) begin
         pc_d       = {redir_tgt[ADDR_W-1:2], 2'b00};
         state_d    = RUN;
         redirect_d = 1'b1;
         misalign_d = (redir_tgt[1:0] != 2'b00);
      end else if (hold_req) begin
         state_d = HOLD;
      end else begin
         unique case (state_q)
            BOOT: state_d = RUN;
            HOLD: state_d = RUN;
            RUN: begin
               state_d = RUN;
               if (accept) begin
                  pc_d = pc_q + ADDR_W'(PC_STEP);
               end
            end
            default: state_d = BOOT;
         endcase
      end

      valid_d = (state_d == RUN);
   end

   // State and output registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_ADDR;
         valid_q    <= 1'b0;
         redirect_q <= 1'b0;
         misalign_q <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         redirect_q <= redirect_d;
         misalign_q <= misalign_d;
         cnt_q      <= cnt_d;
      end
   end

   assign pc_o        = pc_q;
   assign pc_valid_o  = valid_q;
   assign redirect_o  = redirect_q;
   assign misalign_o  = misalign_q;
   assign fetch_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and randomized checks of pc_gen against a behavioural model.
// Trap checks are included when PC_TRAP_EN is defined.
module tb_pc_gen;

   localparam int unsigned HOLD_LEVEL = 1;
   localparam logic [31:0] RST_ADDR   = 32'h0000_0000;
`ifdef PC_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_flag;
   logic [31:0] jump_addr;
   logic [2:0]  hold_flag;
   logic        trap_flag;
   logic [31:0] trap_addr;
   logic        fetch_ready;
   logic [31:0] pc;
   logic        pc_valid;
   logic        redirect;
   logic        misalign;
   logic [31:0] fetch_cnt;

   int vectors = 0;
   int errs    = 0;

   // model state: mode 0 = boot, 1 = run, 2 = hold
   int          m_mode;
   logic [31:0] m_pc;
   logic        m_valid;
   logic        m_redir;
   logic        m_mis;
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   pc_gen dut (
      .clk           (clk),
      .rst           (rst),
      .jump_flag_i   (jump_flag),
      .jump_addr_i   (jump_addr),
      .hold_flag_i   (hold_flag),
`ifdef PC_TRAP_EN
      .trap_flag_i   (trap_flag),
      .trap_addr_i   (trap_addr),
`endif
      .fetch_ready_i (fetch_ready),
      .pc_o          (pc),
      .pc_valid_o    (pc_valid),
      .redirect_o    (redirect),
      .misalign_o    (misalign),
      .fetch_cnt_o   (fetch_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic r, input logic jf, input logic [31:0] ja,
                        input logic [2:0] hf, input logic rdy,
                        input logic tf, input logic [31:0] ta);
      rst         = r;
      jump_flag   = jf;
      jump_addr   = ja;
      hold_flag   = hf;
      fetch_ready = rdy;
      trap_flag   = tf;
      trap_addr   = ta;
   endtask

   // Predict the outputs after the coming edge from the inputs now applied.
   task automatic model_update();
      bit          acc;
      bit          use_trap;
      bit          redir;
      logic [31:0] tgt;
      use_trap = TRAP_EN && trap_flag;
      redir    = use_trap || jump_flag;
      tgt      = use_trap ? trap_addr : jump_addr;
      acc      = m_valid && fetch_ready && (int'(hold_flag) < int'(HOLD_LEVEL));
      if (!rst) begin
         m_mode = 0; m_pc = RST_ADDR; m_redir = 0; m_mis = 0; m_cnt = 0;
      end else begin
         if (acc) m_cnt = 32'((64'(m_cnt) + 1) % 64'h1_0000_0000);
         m_redir = redir;
         m_mis   = redir && ((tgt % 4) != 0);
         if (redir) begin
            m_pc   = tgt - (tgt % 4);
            m_mode = 1;
         end else if (int'(hold_flag) >= int'(HOLD_LEVEL)) begin
            m_mode = 2;
         end else begin
            if (m_mode == 1 && acc) m_pc = 32'((64'(m_pc) + 4) % 64'h1_0000_0000);
            m_mode = 1;
         end
      end
      m_valid = (m_mode == 1);
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      chk("model_pc",       pc,               m_pc);
      chk("model_valid",    32'(pc_valid),    32'(m_valid));
      chk("model_redirect", 32'(redirect),    32'(m_redir));
      chk("model_misalign", 32'(misalign),    32'(m_mis));
      chk("model_cnt",      fetch_cnt,        m_cnt);
   endtask

   initial begin
      int unsigned c0;
      m_mode = 0; m_pc = RST_ADDR; m_valid = 0; m_redir = 0; m_mis = 0; m_cnt = 0;

      // reset two cycles, then boot, then run
      drive(0, 0, 0, 0, 0, 0, 0);
      step(); step();
      chk("rst_pc", pc, RST_ADDR);
      chk("rst_valid", 32'(pc_valid), 0);
      chk("rst_cnt", fetch_cnt, 0);
      chk("rst_redirect", 32'(redirect), 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      step();
      chk("boot_valid", 32'(pc_valid), 1);
      chk("boot_pc", pc, RST_ADDR);

      // streaming from 0x0
      drive(1, 0, 0, 0, 1, 0, 0);
      step(); chk("stream_pc1", pc, 32'h4);
      step(); chk("stream_pc2", pc, 32'h8);
      step(); chk("stream_pc3", pc, 32'hC);
      step(); chk("stream_pc4", pc, 32'h10);
      chk("stream_cnt", fetch_cnt, 4);
      drive(1, 0, 0, 0, 0, 0, 0);
      step(); chk("notready_pc", pc, 32'h10);

      // hold at 0x8 for three cycles, then release
      drive(1, 1, 32'h8, 0, 0, 0, 0);
      step(); chk("jump8_pc", pc, 32'h8);
      drive(1, 0, 0, 1, 1, 0, 0);
      step(); step(); step();
      chk("hold_pc", pc, 32'h8);
      chk("hold_valid", 32'(pc_valid), 0);
      drive(1, 0, 0, 0, 1, 0, 0);
      step();
      chk("release_valid", 32'(pc_valid), 1);
      chk("release_pc", pc, 32'h8);
      step(); chk("release_acc_pc", pc, 32'hC);

      // jump while held
      drive(1, 0, 0, 2, 0, 0, 0);
      step();
      drive(1, 1, 32'h100, 2, 0, 0, 0);
      step();
      chk("jhold_pc", pc, 32'h100);
      chk("jhold_redirect", 32'(redirect), 1);
      chk("jhold_valid", 32'(pc_valid), 1);
      drive(1, 0, 0, 0, 0, 0, 0);
      step(); chk("jhold_redirect_off", 32'(redirect), 0);

      // misaligned jump target
      drive(1, 1, 32'h203, 0, 0, 0, 0);
      step();
      chk("mis_pc", pc, 32'h200);
      chk("mis_flag", 32'(misalign), 1);
      drive(1, 0, 0, 0, 0, 0, 0);
      step(); chk("mis_flag_off", 32'(misalign), 0);

`ifdef PC_TRAP_EN
      drive(1, 1, 32'h40, 0, 0, 1, 32'h80);
      step(); chk("trap_prio_pc", pc, 32'h80);
`endif

      // redirect coincident with accept still counts the fetch
      c0 = fetch_cnt;
      drive(1, 1, 32'hFFFF_FFFC, 0, 1, 0, 0);
      step();
      chk("redir_acc_cnt", fetch_cnt, c0 + 1);
      chk("wrap_setup_pc", pc, 32'hFFFF_FFFC);
      drive(1, 0, 0, 0, 1, 0, 0);
      step(); chk("wrap_pc", pc, 32'h0);

      // reset mid-hold with coincident jump
      drive(1, 0, 0, 3, 0, 0, 0);
      step();
      drive(0, 1, 32'h500, 3, 1, 1, 32'h600);
      step();
      chk("rst_hold_pc", pc, RST_ADDR);
      chk("rst_hold_cnt", fetch_cnt, 0);
      chk("rst_hold_redirect", 32'(redirect), 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 39) != 0),
               ($urandom_range(0, 7) == 0),
               ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15)) : $urandom,
               ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0,
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0),
               $urandom);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
